// File: rtl/pcpi_host_link_if.sv
// pcpi_host_link_if: byte streams, request strobes and 6502 slot bus signals of the PCPI host link
// master: the link itself (drives bus, stream status); slave: the bench/host and card side
interface pcpi_host_link_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       reset_req;
  logic       nmi_req;
  logic       busy;
  logic [2:0] addr6502;
  logic       devsel_n;
  logic       rw;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;
  modport master (
    input  tx_data, tx_valid, rx_ready, reset_req, nmi_req, d_in,
    output tx_ready, rx_data, rx_valid, busy, addr6502, devsel_n, rw, d_out, d_oe
  );
  modport slave (
    output tx_data, tx_valid, rx_ready, reset_req, nmi_req, d_in,
    input  tx_ready, rx_data, rx_valid, busy, addr6502, devsel_n, rw, d_out, d_oe
  );
endinterface

// File: rtl/pcpi_host_link.sv
// pcpi_host_link: 6502-side PCPI mailbox initiator turning slot bus cycles into tx/rx byte streams
// Ports: clk, rst_n (async, active low); lnk (pcpi_host_link_if.master) carries the tx/rx
// valid/ready streams, reset_req/nmi_req pulses, busy, and the slot bus addr6502/devsel_n/rw/d_out/d_oe/d_in.
// Option: define PCPI_NMI_EN to latch nmi_req and issue addr-7 NMI accesses.
module pcpi_host_link #(
  parameter int STROBE_LEN = 4,
  parameter int POLL_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pcpi_host_link_if.master  lnk
);
  localparam int CW = $clog2(STROBE_LEN + POLL_GAP + 2);
  typedef enum logic [2:0] {IDLE, GAP, POLL_RX, READ_RX, POLL_TX, WRITE_TX, RST_ACC
`ifdef PCPI_NMI_EN
    , NMI_ACC
`endif
  } state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_tx_full, r_rx_valid, r_rst, r_rr;
  logic [7:0]      r_tx_data, r_rx_data, r_smp;
  logic            w_acc, w_last, w_tx_acc, w_rst_go;
`ifdef PCPI_NMI_EN
  logic            r_nmi;
`endif
  // r_cnt: 0 = SETUP, 1..STROBE_LEN = STROBE, STROBE_LEN+1 = HOLD
  assign w_acc    = !(r_state inside {IDLE, GAP});
  assign w_last   = w_acc && r_cnt == CW'(STROBE_LEN + 1);
  assign w_tx_acc = lnk.tx_valid && !r_tx_full;
  assign w_rst_go = r_state == IDLE && r_rst;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = r_rst ? RST_ACC
`ifdef PCPI_NMI_EN
                   : r_nmi ? NMI_ACC
`endif
                   : (!r_rx_valid && (!r_rr || !r_tx_full)) ? POLL_RX
                   : r_tx_full ? POLL_TX : IDLE;
      GAP:     w_next = (r_cnt == CW'(POLL_GAP - 1)) ? IDLE : GAP;
      POLL_RX: w_next = w_last ? (r_smp[7] ? READ_RX : GAP) : POLL_RX;
      POLL_TX: w_next = w_last ? (r_smp[7] ? GAP : WRITE_TX) : POLL_TX;
      default: w_next = w_last ? IDLE : r_state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_full  <= 1'b0;
      r_tx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
      r_smp      <= 8'h00;
      r_rst      <= 1'b0;
      r_rr       <= 1'b0;
`ifdef PCPI_NMI_EN
      r_nmi      <= 1'b0;
`endif
    end else begin
      // a latched request clears only when IDLE actually launches its access
      r_rst <= (r_rst && r_state != IDLE) || lnk.reset_req;
`ifdef PCPI_NMI_EN
      r_nmi <= (r_nmi && !(r_state == IDLE && !r_rst)) || lnk.nmi_req;
`endif
      if (w_acc && r_state != WRITE_TX && r_cnt == CW'(STROBE_LEN))
        r_smp <= lnk.d_in;
      if (r_state == IDLE && w_next inside {POLL_RX, POLL_TX})
        r_rr <= w_next == POLL_RX;
      // an accept coinciding with the reset access start wins over the clear
      if (w_tx_acc) begin
        r_tx_full <= 1'b1;
        r_tx_data <= lnk.tx_data;
      end else if (w_rst_go || (r_state == WRITE_TX && w_last)) begin
        r_tx_full <= 1'b0;
        r_tx_data <= 8'h00;
      end
      if (w_rst_go) begin
        r_rx_valid <= 1'b0;
        r_rx_data  <= 8'h00;
      end else if (r_state == READ_RX && w_last) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= r_smp;
      end else if (lnk.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end
  assign lnk.busy     = w_acc;
  assign lnk.devsel_n = !(w_acc && r_cnt != '0 && r_cnt <= CW'(STROBE_LEN));
  assign lnk.rw       = r_state != WRITE_TX;
  assign lnk.d_oe     = r_state == WRITE_TX;
  assign lnk.d_out    = r_state == WRITE_TX ? r_tx_data : 8'h00;
  assign lnk.tx_ready = !r_tx_full;
  assign lnk.rx_valid = r_rx_valid;
  assign lnk.rx_data  = r_rx_data;
  assign lnk.addr6502 = r_state == POLL_RX  ? 3'd3 :
                        r_state == POLL_TX  ? 3'd2 :
                        r_state == WRITE_TX ? 3'd1 :
                        r_state == RST_ACC  ? 3'd5 :
`ifdef PCPI_NMI_EN
                        r_state == NMI_ACC  ? 3'd7 : 3'd0;
`else
                        3'd0;
`endif
endmodule

// File: tb/tb_pcpi_host_link.sv
// tb_pcpi_host_link: card model plus scoreboard for the PCPI host link
module tb_pcpi_host_link;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pcpi_host_link_if lnk();
  pcpi_host_link #(.STROBE_LEN(2), .POLL_GAP(2)) dut (.clk(clk), .rst_n(rst_n), .lnk(lnk.master));
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] card_rx_byte = 8'h00;
  bit card_rx_avail = 1'b0;
  int card_busy = 0;
  int n_rd[8];
  int n_wr[8];
  int slen = 0;
  bit prev_dev = 1'b1;
  int wr1_at_rst = -1;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  typedef struct {
    logic [7:0] tx;
    int         busy;
    bit         do_rx;
    logic [7:0] rx;
  } vec_t;
  vec_t vecs[6];
  assign lnk.d_in = lnk.addr6502 == 3'd3 ? {card_rx_avail, 7'h00} :
                    lnk.addr6502 == 3'd2 ? {card_busy != 0, 7'h00} :
                    lnk.addr6502 == 3'd0 ? card_rx_byte : 8'hFF;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  // card side: every access completes on the HOLD cycle (devsel_n back high)
  always @(negedge clk) begin
    if (!rst_n) begin
      slen = 0;
      prev_dev = 1'b1;
    end else begin
      if (!lnk.devsel_n) slen++;
      else if (!prev_dev) begin
        chk("strobe_len", slen, 2);
        chk("hold_oe", int'(lnk.d_oe), int'(!lnk.rw));
        chk("hold_busy", int'(lnk.busy), 1);
        if (lnk.rw) begin
          n_rd[lnk.addr6502]++;
          if (lnk.addr6502 == 3'd2 && card_busy > 0) card_busy--;
          if (lnk.addr6502 == 3'd0) card_rx_avail = 1'b0;
          if (lnk.addr6502 == 3'd5) wr1_at_rst = n_wr[1];
        end else begin
          n_wr[lnk.addr6502]++;
          chk("write_addr", int'(lnk.addr6502), 1);
          chk("write_expected", int'(exp_tx_q.size() > 0), 1);
          if (exp_tx_q.size() > 0) chk("write_data", int'(lnk.d_out), int'(exp_tx_q.pop_front()));
        end
        slen = 0;
      end
      prev_dev = lnk.devsel_n;
    end
  end
  always @(negedge clk) begin
    if (rst_n && lnk.rx_valid && lnk.rx_ready) begin
      chk("rx_expected", int'(exp_rx_q.size() > 0), 1);
      if (exp_rx_q.size() > 0) chk("rx_data", int'(lnk.rx_data), int'(exp_rx_q.pop_front()));
    end
  end
  task automatic set_rx_ready(bit v);
    @(posedge clk);
    #1 lnk.rx_ready = v;
  endtask
  task automatic send(logic [7:0] b, bit push);
    int k = 0;
    @(negedge clk);
    lnk.tx_data = b;
    lnk.tx_valid = 1'b1;
    if (push) exp_tx_q.push_back(b);
    while (!lnk.tx_ready && k < 2000) begin @(negedge clk); k++; end
    chk("tx_accept", int'(lnk.tx_ready), 1);
    @(negedge clk);
    lnk.tx_valid = 1'b0;
    chk("tx_ready_fall", int'(lnk.tx_ready), 0);
  endtask
  task automatic wait_strobe(logic [2:0] a, string name);
    int k = 0;
    while (!(lnk.addr6502 == a && !lnk.devsel_n) && k < 2000) begin @(negedge clk); k++; end
    chk(name, int'(k < 2000), 1);
  endtask
  task automatic wait_hold(logic [2:0] a, string name);
    int k = 0;
    while (!(lnk.addr6502 == a && !lnk.devsel_n) && k < 2000) begin @(negedge clk); k++; end
    while (!lnk.devsel_n && k < 2000) begin @(negedge clk); k++; end
    chk(name, int'(k < 2000), 1);
  endtask
  task automatic wait_rx_valid(bit v, string name);
    int k = 0;
    while (lnk.rx_valid != v && k < 2000) begin @(negedge clk); k++; end
    chk(name, int'(lnk.rx_valid), int'(v));
  endtask
  task automatic wait_wr(int target, string name);
    int k = 0;
    while (n_wr[1] < target && k < 3000) begin @(negedge clk); k++; end
    @(negedge clk);
    chk(name, n_wr[1], target);
  endtask
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int b0, b1, b2, b3, b5, b7, k;
    lnk.tx_data = 8'h00;
    lnk.tx_valid = 1'b0;
    lnk.rx_ready = 1'b0;
    lnk.reset_req = 1'b0;
    lnk.nmi_req = 1'b0;
    vecs[0] = '{8'h01, 0, 1'b1, 8'h80};
    vecs[1] = '{8'hFF, 1, 1'b0, 8'h00};
    vecs[2] = '{8'h80, 2, 1'b1, 8'h7F};
    vecs[3] = '{8'h3C, 0, 1'b1, 8'h00};
    vecs[4] = '{8'hA5, 4, 1'b1, 8'hFF};
    vecs[5] = '{8'h00, 0, 1'b0, 8'h00};
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(lnk.busy), 0);
    chk("rst_devsel_n", int'(lnk.devsel_n), 1);
    chk("rst_rw", int'(lnk.rw), 1);
    chk("rst_addr", int'(lnk.addr6502), 0);
    chk("rst_d_oe", int'(lnk.d_oe), 0);
    chk("rst_d_out", int'(lnk.d_out), 0);
    chk("rst_tx_ready", int'(lnk.tx_ready), 1);
    chk("rst_rx_valid", int'(lnk.rx_valid), 0);
    chk("rst_rx_data", int'(lnk.rx_data), 0);
    rst_n = 1'b1;
    // reset asserted in the middle of a write strobe with rx_valid held
    @(negedge clk);
    card_rx_byte = 8'h11;
    card_rx_avail = 1'b1;
    wait_rx_valid(1'b1, "a_rx_valid");
    send(8'hEE, 1'b0);
    wait_strobe(3'd1, "a_wr_strobe");
    chk("a_oe_before", int'(lnk.d_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("a_devsel_n", int'(lnk.devsel_n), 1);
    chk("a_d_oe", int'(lnk.d_oe), 0);
    chk("a_tx_ready", int'(lnk.tx_ready), 1);
    chk("a_rx_valid_clr", int'(lnk.rx_valid), 0);
    chk("a_busy", int'(lnk.busy), 0);
    exp_tx_q.delete();
    exp_rx_q.delete();
    card_busy = 0;
    card_rx_avail = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // single transmit, card ready immediately
    set_rx_ready(1'b1);
    b1 = n_wr[1];
    b2 = n_rd[2];
    send(8'h5A, 1'b1);
    wait_hold(3'd1, "b_wr_hold");
    chk("b_tx_ready_hold", int'(lnk.tx_ready), 0);
    @(negedge clk);
    chk("b_tx_ready_rise", int'(lnk.tx_ready), 1);
    chk("b_d_oe_after", int'(lnk.d_oe), 0);
    chk("b_polls", n_rd[2] - b2, 1);
    chk("b_writes", n_wr[1] - b1, 1);
    // flow control: three busy polls then a single write
    card_busy = 3;
    b1 = n_wr[1];
    b2 = n_rd[2];
    send(8'hC3, 1'b1);
    wait_wr(b1 + 1, "c_write_seen");
    repeat (30) @(negedge clk);
    chk("c_polls", n_rd[2] - b2, 4);
    chk("c_writes", n_wr[1] - b1, 1);
    chk("c_card_busy", card_busy, 0);
    // table of combined transmit/receive transactions
    for (int i = 0; i < 6; i++) begin
      b0 = n_rd[0];
      b1 = n_wr[1];
      b2 = n_rd[2];
      card_busy = vecs[i].busy;
      if (vecs[i].do_rx) begin
        card_rx_byte = vecs[i].rx;
        exp_rx_q.push_back(vecs[i].rx);
        card_rx_avail = 1'b1;
      end
      send(vecs[i].tx, 1'b1);
      k = 0;
      while ((n_wr[1] < b1 + 1 || exp_rx_q.size() != 0 || lnk.rx_valid) && k < 3000) begin
        @(negedge clk);
        k++;
      end
      repeat (20) @(negedge clk);
      chk("v_writes", n_wr[1] - b1, 1);
      chk("v_polls", n_rd[2] - b2, vecs[i].busy + 1);
      chk("v_reads", n_rd[0] - b0, int'(vecs[i].do_rx));
      chk("v_rx_left", exp_rx_q.size(), 0);
    end
    // receive with backpressure
    set_rx_ready(1'b0);
    card_rx_byte = 8'hA5;
    exp_rx_q.push_back(8'hA5);
    card_rx_avail = 1'b1;
    wait_rx_valid(1'b1, "d_rx_valid");
    chk("d_rx_data", int'(lnk.rx_data), 8'hA5);
    b3 = n_rd[3];
    repeat (40) @(negedge clk);
    chk("d_rx_held", int'(lnk.rx_valid), 1);
    chk("d_rx_data_held", int'(lnk.rx_data), 8'hA5);
    chk("d_no_polls", n_rd[3] - b3, 0);
    set_rx_ready(1'b1);
    wait_rx_valid(1'b0, "d_rx_taken");
    chk("d_rx_left", exp_rx_q.size(), 0);
    repeat (20) @(negedge clk);
    chk("d_polls_resume", int'(n_rd[3] > b3), 1);
    // reset request during a write strobe, with a new byte waiting
    set_rx_ready(1'b0);
    card_rx_byte = 8'h3C;
    card_rx_avail = 1'b1;
    wait_rx_valid(1'b1, "e_rx_valid");
    b1 = n_wr[1];
    b5 = n_rd[5];
    wr1_at_rst = -1;
    send(8'h77, 1'b1);
    wait_strobe(3'd1, "e_wr_strobe");
    lnk.reset_req = 1'b1;
    lnk.tx_data = 8'h99;
    lnk.tx_valid = 1'b1;
    exp_tx_q.push_back(8'h99);
    @(negedge clk);
    lnk.reset_req = 1'b0;
    k = 0;
    while (!lnk.tx_ready && k < 2000) begin @(negedge clk); k++; end
    @(negedge clk);
    lnk.tx_valid = 1'b0;
    k = 0;
    while (n_rd[5] < b5 + 1 && k < 2000) begin @(negedge clk); k++; end
    chk("e_rst_access", n_rd[5] - b5, 1);
    chk("e_write_first", wr1_at_rst, b1 + 1);
    chk("e_rx_cleared", int'(lnk.rx_valid), 0);
    wait_wr(b1 + 2, "e_kept_byte");
    chk("e_tx_left", exp_tx_q.size(), 0);
    set_rx_ready(1'b1);
    // NMI request
    b7 = n_rd[7];
    @(negedge clk);
    lnk.nmi_req = 1'b1;
    @(negedge clk);
    lnk.nmi_req = 1'b0;
`ifdef PCPI_NMI_EN
    k = 0;
    while (!(lnk.addr6502 == 3'd7 && lnk.busy) && k < 2000) begin @(negedge clk); k++; end
    k = 0;
    while (lnk.addr6502 == 3'd7 && lnk.busy && k < 100) begin @(negedge clk); k++; end
    chk("f_nmi_len", k, 4);
    repeat (40) @(negedge clk);
    chk("f_nmi_count", n_rd[7] - b7, 1);
`else
    repeat (60) @(negedge clk);
    chk("f_no_nmi", n_rd[7] - b7, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pcpi_host_link.md
# pcpi_host_link

Synchronous 6502-side initiator for the PCPI mailbox protocol. It runs host-originated slot bus cycles (devsel, rw, address, data) against the card's mailbox registers, and converts them into byte streams with valid/ready handshakes. A bench or FPGA host uses it to talk to the card as an Apple II would: polling status, reading Z80 data, writing data to the Z80, and issuing Z80 reset and NMI strobes.

## Interface
Parameters:
- STROBE_LEN, 4: clk cycles devsel_n is held low per bus access (legal range ≥1).
- POLL_GAP, 2: idle clk cycles between consecutive status polls.

Ports:
- clk in 1: single clock. All logic is on its rising edge.
- rst_n in 1: asynchronous, active-low reset.
- tx_data in 8: byte to send to the Z80.
- tx_valid in 1: tx_data is valid.
- tx_ready out 1: the transmit holding register is empty.
- rx_data out 8: byte received from the Z80.
- rx_valid out 1: rx_data is valid. Held until it is accepted.
- rx_ready in 1: the consumer accepts rx_data.
- reset_req in 1: single-cycle pulse that requests a Z80 reset access.
- nmi_req in 1: single-cycle pulse that requests a Z80 NMI access (only with PCPI_NMI_EN).
- busy out 1: a bus access is in progress.
- addr6502 out 3: slot register address.
- devsel_n out 1: device-select strobe, active low.
- rw out 1: 1 = read, 0 = write.
- d_out out 8: write data.
- d_oe out 1: enables d_out onto the slot data bus.
- d_in in 8: read data from the slot data bus.

## Operation
Register map, as driven by this block:
- 0: read data from the Z80. The card clears its to-6502 flag.
- 1: write data to the Z80. The card sets its to-Z80 flag on devsel_n rising.
- 2: read status. d_in[7] = to-Z80 flag still pending.
- 3: read status. d_in[7] = to-6502 data available.
- 5: any access resets the Z80.
- 7: any access raises the Z80 NMI.

Buffers:
- The transmit holding register loads on tx_valid && tx_ready.
- The receive holding register loads from an addr-0 read. rx_valid clears on rx_valid && rx_ready.

FSM states are IDLE, GAP, POLL_RX, READ_RX, POLL_TX, WRITE_TX, RST_ACC, NMI_ACC.
- IDLE chooses the next action in this priority order:
  1. Latched reset request.
  2. Latched NMI request.
  3. One of the two poll types, alternating round-robin:
     - POLL_RX only when the receive register is empty.
     - POLL_TX only when the transmit register is full.
  4. Otherwise stay in IDLE.
- POLL_RX: reads addr 3. If d_in[7]=1, go to READ_RX; otherwise go to GAP.
- READ_RX: reads addr 0, then loads rx_data and sets rx_valid.
- POLL_TX: reads addr 2. If d_in[7]=0, go to WRITE_TX; otherwise go to GAP.
- WRITE_TX: writes the held byte to addr 1, then empties the transmit register.
- GAP: waits POLL_GAP cycles, then returns to IDLE.
- RST_ACC: performs a read access to addr 5. It also empties both holding registers and clears rx_valid.
- NMI_ACC: performs a read access to addr 7.
- reset_req and nmi_req are latched into sticky bits. Each bit clears when its access starts.

## Timing
Every bus access is exactly STROBE_LEN+2 cycles:
- SETUP, 1 cycle: addr6502 and rw are driven; devsel_n=1. For writes, d_oe=1.
- STROBE, STROBE_LEN cycles: devsel_n=0. Reads sample d_in on the last strobe cycle.
- HOLD, 1 cycle: devsel_n=1. Address, rw, d_out and d_oe remain stable.
- Next cycle: d_oe=0. Before a read, d_oe is always 0.

Handshake and status timing:
- busy is 1 from SETUP through HOLD inclusive.
- tx_ready falls the cycle after accept. It rises the cycle after the WRITE_TX HOLD.
- rx_valid rises the cycle after the READ_RX HOLD.

Minimum latencies:
- tx accept to devsel_n rising on addr 1: 2·(STROBE_LEN+2)+1 cycles.
- addr-3 flag seen to rx_valid: 2·(STROBE_LEN+2)+1 cycles.

Reset and simultaneous events:
- On rst_n low, immediately: devsel_n=1, rw=1, addr6502=0, d_out=0, d_oe=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0, request latches=0, round-robin pointer=RX, state=IDLE.
- Requests arriving mid-access are served after the current access completes. An access is never truncated.
- A tx accept in the same cycle as RST_ACC start is kept. The RST_ACC clear applies only to bytes held before the access.
- rx_ready asserted with rx_valid=0 has no effect.

## Configuration
- PCPI_NMI_EN defined: nmi_req is latched, and NMI_ACC issues an addr-7 access.
- PCPI_NMI_EN undefined: nmi_req is ignored, NMI_ACC is removed, and addr 7 is never driven.

## Test plan
All scenarios use STROBE_LEN=2 and POLL_GAP=2.
- Reset values: assert rst_n low mid-strobe -> devsel_n=1, d_oe=0, tx_ready=1, rx_valid=0 in the same cycle.
- Transmit: tx_data=0x5A accepted; card model has addr-2 bit7=0 -> one addr-2 read, then an addr-1 write with d_out=0x5A and a 2-cycle strobe; tx_ready=1 after HOLD.
- Flow control: addr-2 bit7=1 for three polls, then 0 -> three POLL_TX/GAP loops, then exactly one addr-1 write.
- Receive with backpressure: card offers 0xA5 at addr 0 with addr-3 bit7=1; rx_ready=0 -> rx_data=0xA5, rx_valid held, no further addr-3 polls until rx_ready=1.
- Reset priority: reset_req pulsed during a WRITE_TX strobe with tx_valid pending -> the write completes, then an addr-5 access, and rx_valid=0 afterwards.
- NMI: with PCPI_NMI_EN, nmi_req -> one addr-7 access of 4 cycles. Without it -> no addr-7 access.
